// File: rtl/pierce_pkg.sv
// Shared types for the Pierce-arrow serial logic unit.
//   op_t    : 3-bit operation select presented on the top-level op port
//   state_t : sequencing states of the serial evaluator
//   OP_COUNT: number of distinct operations
package pierce_pkg;

    localparam int unsigned OP_W     = 3;
    localparam int unsigned OP_COUNT = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOT_A = 3'd0,
        OP_OR    = 3'd1,
        OP_AND   = 3'd2,
        OP_IMP   = 3'd3,
        OP_NOR   = 3'd4,
        OP_NAND  = 3'd5,
        OP_XOR   = 3'd6,
        OP_XNOR  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pierce_arrow.sv
// Two-input Pierce arrow (NOR), the only Boolean primitive of the unit.
//   a, b : inputs
//   y    : a NOR b
module pierce_arrow (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a | b);

endmodule

// File: rtl/pierce_bit_cell.sv
// Combinational 1-bit Boolean cell. Every candidate function is built only
// from Pierce arrows; op merely selects which network output drives y.
//   a, b : operand bits
//   op   : operation select
//   y    : result bit
module pierce_bit_cell
    import pierce_pkg::*;
(
    input  logic a,
    input  logic b,
    input  op_t  op,
    output logic y
);

    logic n_a;      // NOT a
    logic n_b;      // NOT b
    logic nor_ab;   // a NOR b
    logic or_ab;    // NOT(a NOR b)
    logic and_ab;   // (NOT a) NOR (NOT b)
    logic nand_ab;  // NOT(and)
    logic nimp_ab;  // (NOT a) NOR b  == a & ~b
    logic imp_ab;   // NOT(nimp)
    logic xq;       // a NOR (a NOR b)
    logic xr;       // b NOR (a NOR b)
    logic xnor_ab;  // xq NOR xr
    logic xor_ab;   // NOT(xnor)

    pierce_not   u_not_a  (.x(a),       .y(n_a));
    pierce_not   u_not_b  (.x(b),       .y(n_b));
    pierce_arrow u_nor    (.a(a),       .b(b),       .y(nor_ab));
    pierce_not   u_or     (.x(nor_ab),  .y(or_ab));
    pierce_arrow u_and    (.a(n_a),     .b(n_b),     .y(and_ab));
    pierce_not   u_nand   (.x(and_ab),  .y(nand_ab));
    pierce_arrow u_nimp   (.a(n_a),     .b(b),       .y(nimp_ab));
    pierce_not   u_imp    (.x(nimp_ab), .y(imp_ab));

    // Four-arrow XNOR network sharing the a NOR b term.
    pierce_arrow u_xq     (.a(a),       .b(nor_ab),  .y(xq));
    pierce_arrow u_xr     (.a(b),       .b(nor_ab),  .y(xr));
    pierce_arrow u_xnor   (.a(xq),      .b(xr),      .y(xnor_ab));
    pierce_not   u_xor    (.x(xnor_ab), .y(xor_ab));

    // Output select only; no data-path logic here.
    always_comb begin
        y = 1'b0;
        case (op)
            OP_NOT_A: y = n_a;
            OP_OR:    y = or_ab;
            OP_AND:   y = and_ab;
            OP_IMP:   y = imp_ab;
            OP_NOR:   y = nor_ab;
            OP_NAND:  y = nand_ab;
            OP_XOR:   y = xor_ab;
            OP_XNOR:  y = xnor_ab;
            default:  y = 1'b0;
        endcase
    end

endmodule

// File: rtl/pierce_not.sv
// Inverter made from a single Pierce arrow with both inputs tied together.
//   x : input
//   y : NOT x
module pierce_not (
    input  logic x,
    output logic y
);

    pierce_arrow u_arrow (
        .a (x),
        .b (x),
        .y (y)
    );

endmodule

// File: rtl/pierce_serial_logic_unit.sv
// Bit-serial Boolean unit: evaluates LANES bits per clock through an array of
// NOR-only bit cells, taking WIDTH/LANES cycles per operation, with
// valid/ready handshakes on both sides.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, op)
//   out_valid/out_ready : result handshake (result)
//   busy                : high while evaluating
module pierce_serial_logic_unit
    import pierce_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned STEPS = (LANES == 0) ? 1 : WIDTH / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    // Reject configurations that would leave a partial slice.
    if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_cfg
        $error("pierce_serial_logic_unit: WIDTH (%0d) must be a nonzero multiple of LANES (%0d)",
               WIDTH, LANES);
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    op_t              op_q;
    logic [CNT_W-1:0] step;
    logic [LANES-1:0] lane_y;
    logic             accept;

    // Ready in IDLE, or in DONE when the pending result is being taken now.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Cell array evaluates the low LANES bits of the operand shift registers.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pierce_bit_cell u_cell (
            .a  (a_sh[i]),
            .b  (b_sh[i]),
            .op (op_q),
            .y  (lane_y[i])
        );
    end

    // Sequencer, operand shifters, step counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            op_q      <= OP_NOT_A;
            step      <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        op_q      <= op_t'(op);
                        step      <= '0;
                        result    <= '0;
                        state     <= RUN;
                        busy      <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end

                RUN: begin
                    result[32'(step) * LANES +: LANES] <= lane_y;
                    a_sh <= a_sh >> LANES;
                    b_sh <= b_sh >> LANES;
                    if (step == LAST_STEP) begin
                        // Counter parks on the last step; reloaded on next accept.
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        step <= step + CNT_W'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            // Back-to-back: accept new operands as the result leaves.
                            a_sh   <= a;
                            b_sh   <= b;
                            op_q   <= op_t'(op);
                            step   <= '0;
                            result <= '0;
                            state  <= RUN;
                            busy   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pierce_serial_logic_unit.sv
// Self-checking bench for pierce_serial_logic_unit: WIDTH=8 with LANES=1, 4, 8.
module tb_pierce_serial_logic_unit;

    logic       clk = 1'b0;
    logic       rst;

    // LANES=1 unit
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] a, b, result;
    logic [2:0] op;

    // LANES=4 and LANES=8 units share one stimulus set
    logic       x_valid, x_ordy;
    logic [7:0] x_a, x_b;
    logic [2:0] x_op;
    logic       r4_in_ready, r4_out_valid, r4_busy;
    logic [7:0] r4_result;
    logic       r8_in_ready, r8_out_valid, r8_busy;
    logic [7:0] r8_result;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    localparam logic [7:0] OP_TAB [8] = '{8'h0F, 8'hFC, 8'hC0, 8'hCF,
                                          8'h03, 8'h3F, 8'h3C, 8'hC3};

    always #5 clk = ~clk;

    pierce_serial_logic_unit #(.WIDTH(8), .LANES(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    pierce_serial_logic_unit #(.WIDTH(8), .LANES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(r4_in_ready),
        .a(x_a), .b(x_b), .op(x_op), .out_valid(r4_out_valid), .out_ready(x_ordy),
        .result(r4_result), .busy(r4_busy)
    );

    pierce_serial_logic_unit #(.WIDTH(8), .LANES(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(r8_in_ready),
        .a(x_a), .b(x_b), .op(x_op), .out_valid(r8_out_valid), .out_ready(x_ordy),
        .result(r8_result), .busy(r8_busy)
    );

    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                          input logic [2:0] o);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x | y;
            3'd2:    return x & y;
            3'd3:    return ~x | y;
            3'd4:    return ~(x | y);
            3'd5:    return ~(x & y);
            3'd6:    return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands until accepted; push the expected result on acceptance.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [2:0] top, input logic [7:0] texp);
        int n = 0;
        a = ta; b = tb_v; op = top; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("accept_timeout", 32'(n < 200), 32'd1);
        exp_q.push_back(texp);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    // Consume the current result and compare with the scoreboard head.
    task automatic take(input string tag);
        logic [7:0] e;
        out_ready = 1'b1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(result), 32'(e));
        end
        tick();
    endtask

    initial begin
        int lat;
        int lat4, lat8;
        logic [7:0] res4, res8;
        int sent, cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        x_valid = 1'b0; x_ordy = 1'b0; x_a = '0; x_b = '0; x_op = '0;

        // 1: reset then IMP with latency
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        send(8'hF0, 8'hCC, 3'd3, 8'hCF);
        check("run_busy", 32'(busy), 32'd1);
        wait_valid(lat);
        check("imp_latency", 32'(lat), 32'd8);
        take("imp_result");

        // 2: every operation
        for (int i = 0; i < 8; i++) begin
            send(8'hF0, 8'hCC, 3'(i), OP_TAB[i]);
            wait_valid(lat);
            check("op_latency", 32'(lat), 32'd8);
            take("op_result");
        end

        // 3: backpressure then back-to-back accept
        out_ready = 1'b0;
        send(8'hF0, 8'hCC, 3'd2, 8'hC0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_result", 32'(result), 32'hC0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        a = 8'hAA; b = 8'h55; op = 3'd6; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        check("bp_result", 32'(result), 32'(exp_q.pop_front()));
        exp_q.push_back(8'hFF);
        tick();
        in_valid = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_out_valid", 32'(out_valid), 32'd0);
        wait_valid(lat);
        check("b2b_latency", 32'(lat), 32'd8);
        take("b2b_result");

        // 4: wider lanes
        x_a = 8'hAA; x_b = 8'h0F; x_op = 3'd2; x_valid = 1'b1; x_ordy = 1'b1;
        #1;
        check("l4_in_ready", 32'(r4_in_ready), 32'd1);
        check("l8_in_ready", 32'(r8_in_ready), 32'd1);
        tick();
        x_valid = 1'b0;
        lat4 = 0; lat8 = 0; res4 = '0; res8 = '0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (r4_out_valid && lat4 == 0) begin lat4 = c; res4 = r4_result; end
            if (r8_out_valid && lat8 == 0) begin lat8 = c; res8 = r8_result; end
        end
        check("l4_latency", 32'(lat4), 32'd2);
        check("l4_result", 32'(res4), 32'h0A);
        check("l8_latency", 32'(lat8), 32'd1);
        check("l8_result", 32'(res8), 32'h0A);

        // 5: asynchronous reset mid-operation
        send(8'hF0, 8'hCC, 3'd6, 8'h3C);
        repeat (3) tick();
        check("mid_busy", 32'(busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_result", 32'(result), 32'h00);
        void'(exp_q.pop_front());
        #1;
        rst = 1'b0;
        tick();
        send(8'hF0, 8'hCC, 3'd5, 8'h3F);
        wait_valid(lat);
        check("post_rst_latency", 32'(lat), 32'd8);
        take("post_rst_result");

        // 6: random transactions with input churn and random out_ready
        sent = 0; cyc = 0;
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 40000) begin
            out_ready = ($urandom_range(0, 1) == 1);
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 3'($urandom);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("rand_sb_empty", 32'd0, 32'd1);
                else check("rand_result", 32'(result), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(a, b, op));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_sent", 32'(sent), 32'd1000);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
